// File: rtl/pulse_sched_pkg.sv
// Shared constants and FSM state encoding for the pulse-train scheduler.
package pulse_sched_pkg;

  localparam int unsigned DefLenW   = 8;
  localparam int unsigned DefCntW   = 4;
  localparam int unsigned DefGapCyc = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

endpackage

// File: rtl/pulse_train_sched_if.sv
// Request/operand/strobe bundle between requesters and the pulse-train scheduler.
interface pulse_train_sched_if #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 4
);
  logic [1:0]       req;
  logic [LEN_W-1:0] hi_len_0;
  logic [LEN_W-1:0] lo_len_0;
  logic [CNT_W-1:0] count_0;
  logic [LEN_W-1:0] hi_len_1;
  logic [LEN_W-1:0] lo_len_1;
  logic [CNT_W-1:0] count_1;
  logic [1:0]       ack;
  logic [1:0]       done;
  logic             signal;
  logic             busy;
  logic             owner;

  modport master (
    output req, hi_len_0, lo_len_0, count_0, hi_len_1, lo_len_1, count_1,
    input  ack, done, signal, busy, owner
  );

  modport slave (
    input  req, hi_len_0, lo_len_0, count_0, hi_len_1, lo_len_1, count_1,
    output ack, done, signal, busy, owner
  );
endinterface

// File: rtl/pulse_rr_arb2.sv
// Combinational 2-way round-robin arbiter; the last-owner pointer lives in the parent.
module pulse_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] grant_o,
  output logic       sel_o
);

  always_comb begin
    sel_o = req_i[1];
    if (req_i == 2'b11) sel_o = ~last_owner_i;
    grant_o = 2'b00;
    if (req_i != 2'b00) grant_o = sel_o ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/pulse_train_sched.sv
// Shares one pulse-train generator between two requesters via round-robin grant.
// Optional post-train idle gap enabled by defining PULSE_SCHED_GAP_EN.
module pulse_train_sched
  import pulse_sched_pkg::*;
#(
  parameter int unsigned LEN_W   = DefLenW,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned GAP_CYC = DefGapCyc
) (
  input  logic         clock,
  input  logic         reset_n,
  pulse_train_sched_if.slave bus
);

`ifdef PULSE_SCHED_GAP_EN
  localparam bit GapEn = (GAP_CYC != 0);
`else
  localparam bit GapEn = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic [LEN_W-1:0] hi_q, hi_d;
  logic [LEN_W-1:0] lo_q, lo_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             pend_q, pend_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;

  logic [1:0]       arb_grant;
  logic             arb_sel;
  logic [LEN_W-1:0] hi_sel, lo_sel;
  logic [CNT_W-1:0] cnt_sel;

  pulse_rr_arb2 u_arb (
    .req_i        (bus.req),
    .last_owner_i (last_owner_q),
    .grant_o      (arb_grant),
    .sel_o        (arb_sel)
  );

  // Zero-length phases behave as one cycle.
  always_comb begin
    hi_sel  = arb_sel ? bus.hi_len_1 : bus.hi_len_0;
    lo_sel  = arb_sel ? bus.lo_len_1 : bus.lo_len_0;
    cnt_sel = arb_sel ? bus.count_1  : bus.count_0;
    if (hi_sel == '0) hi_sel = LEN_W'(1);
    if (lo_sel == '0) lo_sel = LEN_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pulse_d      = pulse_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    pend_d       = pend_q;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    signal_d     = signal_q;
    busy_d       = busy_q;

    case (state_q)
      StIdle: begin
        signal_d = 1'b0;
        busy_d   = 1'b0;
        // A zero-count grant reports done one cycle later and blocks re-grant meanwhile.
        if (pend_q) begin
          pend_d = 1'b0;
          done_d = owner_q ? 2'b10 : 2'b01;
        end else if (bus.req != 2'b00) begin
          ack_d        = arb_grant;
          owner_d      = arb_sel;
          last_owner_d = arb_sel;
          hi_d         = hi_sel;
          lo_d         = lo_sel;
          pulse_d      = cnt_sel;
          if (cnt_sel == '0) begin
            pend_d = 1'b1;
          end else begin
            state_d  = StHigh;
            phase_d  = hi_sel - LEN_W'(1);
            signal_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end

      StHigh: begin
        if (phase_q == '0) begin
          state_d  = StLow;
          phase_d  = lo_q - LEN_W'(1);
          signal_d = 1'b0;
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end

      StLow: begin
        if (phase_q != '0) begin
          phase_d = phase_q - LEN_W'(1);
        end else if (pulse_q != CNT_W'(1)) begin
          state_d  = StHigh;
          pulse_d  = pulse_q - CNT_W'(1);
          phase_d  = hi_q - LEN_W'(1);
          signal_d = 1'b1;
        end else if (GapEn) begin
          state_d = StGap;
          phase_d = LEN_W'(GAP_CYC - 1);
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = owner_q ? 2'b10 : 2'b01;
        end
      end

      StGap: begin
        if (phase_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = owner_q ? 2'b10 : 2'b01;
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end

      default: begin
        state_d  = StIdle;
        signal_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      pulse_q      <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      pend_q       <= 1'b0;
      ack_q        <= 2'b00;
      done_q       <= 2'b00;
      signal_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pulse_q      <= pulse_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      pend_q       <= pend_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      signal_q     <= signal_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.done   = done_q;
  assign bus.signal = signal_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;

endmodule

// File: tb/tb_pulse_train_sched.sv
// Scoreboard bench for pulse_train_sched: per-cycle expected outputs queued at stimulus time.
module tb_pulse_train_sched;

  localparam int unsigned LenW   = 8;
  localparam int unsigned CntW   = 4;
  localparam int unsigned GapCyc = 4;
`ifdef PULSE_SCHED_GAP_EN
  localparam int GapEn = 1;
`else
  localparam int GapEn = 0;
`endif

  typedef struct packed {
    logic       sig;
    logic       busy;
    logic [1:0] ack;
    logic [1:0] done;
    logic       owner;
  } obs_t;

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  pulse_train_sched_if #(.LEN_W(LenW), .CNT_W(CntW)) bus ();

  pulse_train_sched #(.LEN_W(LenW), .CNT_W(CntW), .GAP_CYC(GapCyc)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic obs_t observe();
    return {bus.signal, bus.busy, bus.ack, bus.done, bus.owner};
  endfunction

  // Reference model: expected outputs from the ack cycle through the done cycle.
  task automatic push_train(input int idx, input int hi, input int lo, input int cnt);
    int         h  = (hi == 0) ? 1 : hi;
    int         l  = (lo == 0) ? 1 : lo;
    logic [1:0] oh = (idx == 1) ? 2'b10 : 2'b01;
    logic       own = (idx == 1);
    obs_t       e;
    if (cnt == 0) begin
      e = {1'b0, 1'b0, oh, 2'b00, own};
      exp_q.push_back(e);
    end else begin
      for (int p = 0; p < cnt; p++) begin
        for (int i = 0; i < h + l; i++) begin
          e = {(i < h), 1'b1, (p == 0 && i == 0) ? oh : 2'b00, 2'b00, own};
          exp_q.push_back(e);
        end
      end
      for (int g = 0; g < GapEn * GapCyc; g++) begin
        e = {1'b0, 1'b1, 2'b00, 2'b00, own};
        exp_q.push_back(e);
      end
    end
    e = {1'b0, 1'b0, 2'b00, oh, own};
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    obs_t o;
    reset_n      = 1'b0;
    bus.req      = 2'b00;
    bus.hi_len_0 = '0;
    bus.lo_len_0 = '0;
    bus.count_0  = '0;
    bus.hi_len_1 = '0;
    bus.lo_len_1 = '0;
    bus.count_1  = '0;
    repeat (3) @(negedge clock);
    o = observe();
    checks++;
    if (o !== 7'b0) begin
      failures++;
      $display("FAIL reset_in got=%b exp=%b", o, 7'b0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    o = observe();
    checks++;
    if (o !== 7'b0) begin
      failures++;
      $display("FAIL reset_after got=%b exp=%b", o, 7'b0);
    end
  endtask

  task automatic test_tie();
    obs_t e, o;
    int   n;
    bus.hi_len_0 = 8'd2; bus.lo_len_0 = 8'd2; bus.count_0 = 4'd1;
    bus.hi_len_1 = 8'd2; bus.lo_len_1 = 8'd2; bus.count_1 = 4'd1;
    for (int r = 0; r < 2; r++) begin
      push_train(0, 2, 2, 1);
      push_train(1, 2, 2, 1);
      bus.req = 2'b11;
      n = 0;
      do begin @(negedge clock); n++; end while (bus.ack == 2'b00 && n < 8);
      checks++;
      if (n != 1) begin
        failures++;
        $display("FAIL tie_ack_latency round=%0d got=%0d exp=1", r, n);
      end
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL tie round=%0d cyc=%0d got=%b exp=%b", r, c, o, e);
        end
        bus.req = bus.req & ~bus.ack;
        @(negedge clock);
      end
      bus.req = 2'b00;
    end
  endtask

  task automatic test_single();
    obs_t e, o;
    int   n = 0;
    bus.hi_len_0 = 8'd3; bus.lo_len_0 = 8'd3; bus.count_0 = 4'd3;
    push_train(0, 3, 3, 3);
    bus.req = 2'b01;
    do begin @(negedge clock); n++; end while (bus.ack == 2'b00 && n < 8);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL single_ack_latency got=%0d exp=1", n);
    end
    for (int c = 0; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL single cyc=%0d got=%b exp=%b", c, o, e);
      end
      bus.req = bus.req & ~bus.ack;
      @(negedge clock);
    end
    bus.req = 2'b00;
  endtask

  task automatic test_zero_len();
    obs_t e, o;
    int   n = 0;
    bus.hi_len_0 = 8'd0; bus.lo_len_0 = 8'd0; bus.count_0 = 4'd2;
    push_train(0, 0, 0, 2);
    bus.req = 2'b01;
    do begin @(negedge clock); n++; end while (bus.ack == 2'b00 && n < 8);
    for (int c = 0; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL zero_len cyc=%0d got=%b exp=%b", c, o, e);
      end
      bus.req = bus.req & ~bus.ack;
      @(negedge clock);
    end
    bus.req = 2'b00;
  endtask

  task automatic test_count_zero();
    obs_t e, o;
    int   n = 0;
    bus.hi_len_1 = 8'd5; bus.lo_len_1 = 8'd5; bus.count_1 = 4'd0;
    push_train(1, 5, 5, 0);
    bus.req = 2'b10;
    do begin @(negedge clock); n++; end while (bus.ack == 2'b00 && n < 8);
    for (int c = 0; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL count_zero cyc=%0d got=%b exp=%b", c, o, e);
      end
      bus.req = bus.req & ~bus.ack;
      @(negedge clock);
    end
    o = observe();
    checks++;
    if (o !== 7'b0000001) begin
      failures++;
      $display("FAIL count_zero_idle got=%b exp=%b", o, 7'b0000001);
    end
    bus.req = 2'b00;
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic sigs[$];
    int   n = 0, acks = 0, i = 0, run = 0;
    int   exp_run = 3 + 1 + GapEn * GapCyc;
    bus.hi_len_0 = 8'd2; bus.lo_len_0 = 8'd3; bus.count_0 = 4'd1;
    push_train(0, 2, 3, 1);
    push_train(0, 2, 3, 1);
    bus.req = 2'b01;
    do begin @(negedge clock); n++; end while (bus.ack == 2'b00 && n < 8);
    for (int c = 0; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      o = observe();
      sigs.push_back(o.sig);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", c, o, e);
      end
      if (bus.ack != 2'b00) acks++;
      if (acks >= 2) bus.req = 2'b00;
      @(negedge clock);
    end
    bus.req = 2'b00;
    while (i < sigs.size() && sigs[i] == 1'b1) i++;
    while (i < sigs.size() && sigs[i] == 1'b0) begin run++; i++; end
    checks++;
    if (run != exp_run) begin
      failures++;
      $display("FAIL b2b_low_gap got=%0d exp=%0d", run, exp_run);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    int   n = 0;
    bus.hi_len_0 = 8'd5; bus.lo_len_0 = 8'd5; bus.count_0 = 4'd3;
    bus.req = 2'b01;
    do begin @(negedge clock); n++; end while (bus.ack == 2'b00 && n < 8);
    bus.req = 2'b00;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.signal, bus.busy} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_pre got=%b exp=11", {bus.signal, bus.busy});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.signal, bus.busy} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_drop got=%b exp=00", {bus.signal, bus.busy});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if ({bus.done, bus.busy} !== 3'b000) begin
        failures++;
        $display("FAIL rst_mid_hold k=%0d got=%b exp=000", k, {bus.done, bus.busy});
      end
    end
    reset_n = 1'b1;
    @(negedge clock);
    bus.hi_len_0 = 8'd1; bus.lo_len_0 = 8'd1; bus.count_0 = 4'd1;
    bus.hi_len_1 = 8'd1; bus.lo_len_1 = 8'd1; bus.count_1 = 4'd1;
    push_train(0, 1, 1, 1);
    push_train(1, 1, 1, 1);
    bus.req = 2'b11;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.ack == 2'b00 && n < 8);
    for (int c = 0; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_mid_tie cyc=%0d got=%b exp=%b", c, o, e);
      end
      bus.req = bus.req & ~bus.ack;
      @(negedge clock);
    end
    bus.req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_zero_len();
    test_count_zero();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
